// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered, fixed-priority interrupt controller driving the
// RI5CY irq/id/ack interface, configured over the req/gnt/rvalid data bus.
// Build macro IRQC_SYNC_EN: adds a 2-flop synchronizer on every irq_src bit
// (irq_src rise to core_irq becomes 4 cycles instead of 2).

// Per-source cell: optional synchronizer, rising-edge detect, sticky pending bit.
module irq_ctrl_cell (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic src,
  input  logic set_sw,
  input  logic clr,
  output logic pend
);
  logic src_q;
  logic src_prev;

`ifdef IRQC_SYNC_EN
  logic sync1, sync2;
  // two-flop synchronizer for sources not clocked by HCLK
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end
  assign src_q = sync2;
`else
  assign src_q = src;
`endif

  // last-cycle sample; a level held high yields exactly one rise
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) src_prev <= 1'b0;
    else          src_prev <= src_q;
  end

  // sticky pending: any set (edge or software) beats any clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) pend <= 1'b0;
    else          pend <= (src_q & ~src_prev) | set_sw | (pend & ~clr);
  end
endmodule

module irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int IRQ_BASE_ID = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               irqc_sel,
  input  logic               irqc_req,
  input  logic               irqc_write,
  input  logic [1:0]         irqc_addr,
  input  logic [31:0]        irqc_wdata,
  output logic               irqc_gnt,
  output logic               irqc_rvalid,
  output logic [31:0]        irqc_rdata,
  output logic               core_irq,
  output logic [4:0]         core_irq_id,
  input  logic               core_irq_ack,
  input  logic [4:0]         core_irq_ack_id
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [4:0] BASE_ID = 5'(IRQ_BASE_ID);

  state_t             state;
  logic [NUM_IRQ-1:0] enable, pending, cand, sw_set, clr, sel_oh;
  logic [4:0]         sel_idx, win_idx;
  logic               gnt, wr, ack_hit, sel_live;
  logic [31:0]        rd_mux;
  logic               wdata_unused;

  // only the low NUM_IRQ write-data bits carry meaning
  assign wdata_unused = ^irqc_wdata;

  assign gnt      = irqc_sel & irqc_req;
  assign irqc_gnt = gnt;
  assign wr       = gnt & irqc_write;
  assign cand     = pending & enable;
  assign sw_set   = (wr && irqc_addr == 2'd2) ? irqc_wdata[NUM_IRQ-1:0] : '0;
  assign ack_hit  = (state == REQ) && core_irq_ack && (core_irq_ack_id == core_irq_id);
  assign sel_live = |(cand & sel_oh);

  // one-hot of the latched source, used for ack-clear and withdraw detect
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (sel_idx == 5'(i)) sel_oh[i] = 1'b1;
  end

  // clear requests: software W1C plus the acknowledged source
  always_comb begin
    clr = '0;
    if (wr && irqc_addr == 2'd1) clr = irqc_wdata[NUM_IRQ-1:0];
    if (ack_hit)                 clr = clr | sel_oh;
  end

  // fixed priority: lowest set index wins
  always_comb begin
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (cand[i]) win_idx = 5'(i);
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    irq_ctrl_cell u_cell (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .src     (irq_src[g]),
      .set_sw  (sw_set[g]),
      .clr     (clr[g]),
      .pend    (pending[g])
    );
  end

  // register read mux
  always_comb begin
    case (irqc_addr)
      2'd0:    rd_mux = 32'(enable);
      2'd1:    rd_mux = 32'(pending);
      2'd2:    rd_mux = '0;
      default: rd_mux = {26'b0, core_irq, core_irq_id};
    endcase
  end

  // ENABLE register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                     enable <= '0;
    else if (wr && irqc_addr == 2'd0) enable <= irqc_wdata[NUM_IRQ-1:0];
  end

  // bus response: one rvalid per grant, rdata zero for writes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irqc_rvalid <= 1'b0;
      irqc_rdata  <= '0;
    end else begin
      irqc_rvalid <= gnt;
      if (gnt) irqc_rdata <= irqc_write ? 32'h0 : rd_mux;
    end
  end

  // request FSM with registered core_irq / core_irq_id; no preemption in REQ
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      sel_idx     <= '0;
      core_irq    <= 1'b0;
      core_irq_id <= '0;
    end else begin
      case (state)
        IDLE: if (|cand) begin
          sel_idx     <= win_idx;
          core_irq_id <= BASE_ID + win_idx;
          core_irq    <= 1'b1;
          state       <= REQ;
        end
        REQ: if (ack_hit) begin
          core_irq <= 1'b0;
          state    <= HOLD;
        end else if (!sel_live) begin
          core_irq <= 1'b0;
          state    <= IDLE;
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
